// File: rtl/spike_dispatch.sv
// Spike vector dispatcher: latches a 64-bit spike vector and emits one address per set bit,
// lowest index first, over a valid/ready handshake. Optional macro: SPIKE_DISPATCH_COUNT_EN.
module spike_dispatch #(
  parameter int unsigned OUT_ADDR_W = 8,
  parameter int unsigned ADDR_BASE  = 0,
  parameter int unsigned TS_W       = 16
) (
  input  logic                  CLOCK_50,
  input  logic                  rst,
  input  logic [31:0]           spike_0_in,
  input  logic [31:0]           spike_1_in,
  input  logic                  start,
  output logic                  evt_valid,
  output logic [OUT_ADDR_W-1:0] evt_addr,
  input  logic                  evt_ready,
  output logic                  busy,
  output logic                  done,
  output logic [TS_W-1:0]       timestep,
  output logic                  overrun,
  output logic [6:0]            evt_count
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [63:0]     shadow_q, shadow_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic            ovr_q, ovr_d;
  logic [63:0]     shadow_clr;
  logic [5:0]      low_idx;
  logic            accept, xfer;

  assign accept     = (state_q == StIdle) && start;
  assign xfer       = (state_q == StScan) && evt_ready;
  // Clearing the lowest set bit keeps the ascending emission order without an index compare.
  assign shadow_clr = shadow_q & (shadow_q - 64'd1);

  always_comb begin
    low_idx = '0;
    for (int i = 63; i >= 0; i--) begin
      if (shadow_q[i]) low_idx = 6'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    ts_d     = ts_q;
    ovr_d    = ovr_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          shadow_d = {spike_1_in, spike_0_in};
          state_d  = (|{spike_1_in, spike_0_in}) ? StScan : StDone;
        end
      end
      StScan: begin
        if (start) ovr_d = 1'b1;
        if (evt_ready) begin
          shadow_d = shadow_clr;
          if (shadow_clr == 64'd0) state_d = StDone;
        end
      end
      StDone: begin
        if (start) ovr_d = 1'b1;
        ts_d    = ts_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      ts_q     <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      ts_q     <= ts_d;
      ovr_q    <= ovr_d;
    end
  end

`ifdef SPIKE_DISPATCH_COUNT_EN
  logic [6:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (xfer) begin
      cnt_d = cnt_q + 7'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign evt_count = cnt_q;
`else
  assign evt_count = 7'd0;
`endif

  assign evt_valid = (state_q == StScan);
  assign busy      = (state_q == StScan);
  assign done      = (state_q == StDone);
  assign timestep  = ts_q;
  assign overrun   = ovr_q;
  // Gated to zero outside SCAN so reset and idle show address 0 regardless of ADDR_BASE.
  assign evt_addr  = (state_q == StScan) ? OUT_ADDR_W'(ADDR_BASE + 32'(low_idx)) : '0;

endmodule

// File: doc/spike_dispatch.md
SPIKE_DISPATCH -- requirements
Module: spike_dispatch

Interface
REQ-001 Parameter: OUT_ADDR_W, 8, width of the emitted neuron address.
REQ-002 Parameter: ADDR_BASE, 0, offset added to every spike index before emission.
REQ-003 Parameter: TS_W, 16, width of the timestep counter.
REQ-004 Port: CLOCK_50  in  1  single clock; all logic on its rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: spike_0_in  in  32  spike bits for indices 0..31 (bit i = index i).
REQ-007 Port: spike_1_in  in  32  spike bits for indices 32..63 (bit i = index 32+i).
REQ-008 Port: start  in  1  one-cycle request to dispatch the current spike vector.
REQ-009 Port: evt_valid  out  1  event address valid.
REQ-010 Port: evt_addr  out  OUT_ADDR_W  (ADDR_BASE + index) truncated to OUT_ADDR_W bits.
REQ-011 Port: evt_ready  in  1  downstream accepts the event.
REQ-012 Port: busy  out  1  high in SCAN state.
REQ-013 Port: done  out  1  one-cycle pulse at the end of each dispatch.
REQ-014 Port: timestep  out  TS_W  count of completed dispatches; wraps modulo 2^TS_W.
REQ-015 Port: overrun  out  1  sticky flag: start seen while busy or done.
REQ-016 Port: evt_count  out  7  events emitted in the current or last dispatch (see Configuration).

Function
REQ-017 FSM states: IDLE, SCAN, DONE; state is registered.
REQ-018 In IDLE, start=1 latches {spike_1_in, spike_0_in} into a 64-bit shadow register. Next state is SCAN if the vector is nonzero, else DONE.
REQ-019 In SCAN, evt_valid=1; evt_addr is derived from the lowest set bit of shadow.
REQ-020 Handshake: the event transfers on a cycle with evt_valid=1 and evt_ready=1. The transfer clears that bit in shadow.
REQ-021 evt_addr is stable and evt_valid stays high while evt_ready=0; no event is dropped or duplicated.
REQ-022 A transfer that clears the last set bit moves to DONE. Otherwise the FSM stays in SCAN, and the next address is presented in the following cycle (throughput 1 event/cycle).
REQ-023 Latency: start accepted in cycle 0 gives the first evt_valid in cycle 1. With k spikes and evt_ready held high, events occupy cycles 1..k and done is high in cycle k+1. An empty vector gives done in cycle 1.
REQ-024 Events are emitted in strictly ascending index order, 0 to 63.
REQ-025 DONE lasts exactly one cycle: done=1, timestep increments by 1 (wrap 2^TS_W-1 -> 0), then IDLE.
REQ-026 A start in SCAN or DONE is ignored. Shadow is unchanged and overrun is set to 1; overrun is cleared only by rst.
REQ-027 evt_valid=0 in IDLE and DONE, regardless of evt_ready.
REQ-028 Spike input changes after the latch cycle have no effect on the dispatch in progress.
REQ-029 Address arithmetic is unsigned modulo 2^OUT_ADDR_W.

Reset
REQ-030 rst=1 at a rising edge forces, in the same edge: state=IDLE, shadow=0, evt_valid=0, evt_addr=0, busy=0, done=0, timestep=0, overrun=0, evt_count=0.
REQ-031 rst during SCAN aborts the dispatch. No further events are emitted and done does not pulse.
REQ-032 rst has priority over start in the same cycle.

Configuration
REQ-033 Macro SPIKE_DISPATCH_COUNT_EN defined: evt_count clears to 0 when start is accepted, increments by 1 per transfer, and holds its value through DONE and IDLE until the next accepted start.
REQ-034 Macro SPIKE_DISPATCH_COUNT_EN undefined: no counter logic exists and evt_count is constant 0. All other behaviour is identical.

Verification
REQ-035 spike_0_in=1, spike_1_in=2, start pulse, evt_ready=1 -> evt_addr 0 (cycle 1), 33 (cycle 2); done in cycle 3; timestep=1; evt_count=2 (COUNT_EN).
REQ-036 Both words 0, start pulse -> no evt_valid; done in cycle 1; timestep increments.
REQ-037 spike_0_in=32'h8000_0001, evt_ready low for cycles 1-3 -> evt_addr 0 held stable cycles 1-4; addr 31 in cycle 5; done in cycle 6.
REQ-038 Both words all-ones with ADDR_BASE=200, OUT_ADDR_W=8 -> 64 events 200..255 then 0..7 (wrap); done in cycle 65.
REQ-039 Second start during SCAN -> ignored; overrun=1 and stays 1 until rst; the event sequence is unchanged.
REQ-040 rst asserted mid-SCAN -> next cycle evt_valid=0, busy=0, timestep=0, no done pulse.
